// File: rtl/ram16_master_pkg.sv
// Shared types and constants for the 16x8 RAM bus master.
// Holds op encodings, FSM state encodings and bus widths.
// Imported by the master top and its bus pad.
package ram16_master_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        OP_RD     = 2'b00,
        OP_WR     = 2'b01,
        OP_PRESET = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_TURN = 3'd3,
        ST_CTL  = 3'd4,
        ST_RSP  = 3'd5
    } state_e;

    // Down-counter load value for a phase lasting 'cycles' cycles.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ram16_bus_pad.sv
// Tristate pad for the shared RAM data bus: registered drive enable/data and read capture.
// Latency: drive appears one cycle after i_oe; capture lands on the edge where i_cap_en is high.
// No backpressure; the master sequences drive and capture.
module ram16_bus_pad
    import ram16_master_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_oe,
    input  logic [DATA_W-1:0] i_dout,
    input  logic              i_cap_en,
    output logic              o_oe,
    output logic [DATA_W-1:0] o_cap,
    inout  wire  [DATA_W-1:0] io_data
);

    logic              r_oe;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_cap;

    // Output register and drive enable; the bus is released whenever r_oe is low.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_oe   <= 1'b0;
            r_dout <= '0;
        end else begin
            r_oe <= i_oe;
            if (i_oe) begin
                r_dout <= i_dout;
            end
        end
    end

    // Read capture; whatever is on the bus (including X/Z) is stored unchanged.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cap <= '0;
        end else if (i_cap_en) begin
            r_cap <= io_data;
        end
    end

    assign io_data = r_oe ? r_dout : {DATA_W{1'bz}};
    assign o_oe    = r_oe;
    assign o_cap   = r_cap;

endmodule

// File: rtl/ram16x8_bus_master.sv
// Initiator for the 16x8 bidirectional RAM; optional write readback compare under RAM16_WR_VERIFY_EN.
// Latency accept->rsp_valid: read RD_LAT+2, write 2 (RD_LAT+4 with verify), preset/clear PULSE_CYC+1.
// req_ready only in IDLE; response held stable until rsp_ready, one idle cycle between transactions.
module ram16x8_bus_master
    import ram16_master_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int PULSE_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    inout  wire  [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic              preset,
    output logic              mem_reset_n
);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [ADDR_W-1:0] r_address;
    logic              r_read;
    logic              r_write;
    logic              r_preset;
    logic              r_mem_rst_n;
`ifdef RAM16_WR_VERIFY_EN
    logic              r_rsp_err;
    logic              r_vfy_pending;
    logic              r_vfy_wr;
    logic [DATA_W-1:0] r_wdata;
`endif

    logic              w_accept;
    logic              w_oe_nxt;
    logic              w_cap_en;
    logic              w_bus_oe;
    logic [DATA_W-1:0] w_cap;

    assign w_accept = (r_state == ST_IDLE) && req_valid && r_req_ready;
    // Drive the bus exactly during the WR cycle that follows a write acceptance.
    assign w_oe_nxt = w_accept && (op_e'(req_op) == OP_WR);
    // Sample the bus on the edge that ends the last read-strobe cycle.
    assign w_cap_en = (r_state == ST_RD) && (r_cnt == '0);

    ram16_bus_pad u_pad (
        .clk      (clk),
        .i_rst_n  (reset),
        .i_oe     (w_oe_nxt),
        .i_dout   (req_wdata),
        .i_cap_en (w_cap_en),
        .o_oe     (w_bus_oe),
        .o_cap    (w_cap),
        .io_data  (data)
    );

    // Transaction FSM; every pin-level output is registered on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_address   <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_preset    <= 1'b0;
            r_mem_rst_n <= 1'b1;
`ifdef RAM16_WR_VERIFY_EN
            r_rsp_err     <= 1'b0;
            r_vfy_pending <= 1'b0;
            r_vfy_wr      <= 1'b0;
            r_wdata       <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_address   <= req_addr;
`ifdef RAM16_WR_VERIFY_EN
                        r_wdata       <= req_wdata;
                        r_vfy_wr      <= (op_e'(req_op) == OP_WR);
                        r_vfy_pending <= (op_e'(req_op) == OP_WR);
`endif
                        case (op_e'(req_op))
                            OP_WR: begin
                                r_state <= ST_WR;
                                r_write <= 1'b1;
                            end
                            OP_RD: begin
                                r_state <= ST_RD;
                                r_read  <= 1'b1;
                                r_cnt   <= cnt_load(RD_LAT);
                            end
                            OP_PRESET: begin
                                r_state  <= ST_CTL;
                                r_preset <= 1'b1;
                                r_cnt    <= cnt_load(PULSE_CYC);
                            end
                            OP_CLEAR: begin
                                r_state     <= ST_CTL;
                                r_mem_rst_n <= 1'b0;
                                r_cnt       <= cnt_load(PULSE_CYC);
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    r_write <= 1'b0;
`ifdef RAM16_WR_VERIFY_EN
                    r_state <= ST_TURN;
`else
                    r_state     <= ST_RSP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
`endif
                end
                ST_RD: begin
                    if (r_cnt == '0) begin
                        r_read  <= 1'b0;
                        r_state <= ST_TURN;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_TURN: begin
`ifdef RAM16_WR_VERIFY_EN
                    if (r_vfy_pending) begin
                        // Bus has settled after the write; now read it back.
                        r_vfy_pending <= 1'b0;
                        r_state       <= ST_RD;
                        r_read        <= 1'b1;
                        r_cnt         <= cnt_load(RD_LAT);
                    end else begin
                        r_state     <= ST_RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_cap;
                        r_rsp_err   <= r_vfy_wr && (w_cap != r_wdata);
                    end
`else
                    r_state     <= ST_RSP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_cap;
`endif
                end
                ST_CTL: begin
                    if (r_cnt == '0) begin
                        r_preset    <= 1'b0;
                        r_mem_rst_n <= 1'b1;
                        r_state     <= ST_RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
`ifdef RAM16_WR_VERIFY_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign address     = r_address;
    assign read        = r_read;
    assign write       = r_write;
    assign preset      = r_preset;
    assign mem_reset_n = r_mem_rst_n;
`ifdef RAM16_WR_VERIFY_EN
    assign rsp_err     = r_rsp_err;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ram16x8_bus_master.sv
// Bench for ram16x8_bus_master with a behavioural 16x8 RAM on the shared bus.
// Expected responses come from a reference memory array updated per transaction.
// Checks reset, read/write/preset/clear, stalls, mid-read reset and random traffic.
module tb_ram16x8_bus_master;

    localparam int RD_LAT    = 1;
    localparam int PULSE_CYC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_addr = 4'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    wire  [7:0] data;
    logic [3:0] address;
    logic       read;
    logic       write;
    logic       preset;
    logic       mem_reset_n;

    int checks = 0;
    int errors = 0;

    ram16x8_bus_master #(.RD_LAT(RD_LAT), .PULSE_CYC(PULSE_CYC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .data(data), .address(address), .read(read), .write(write),
        .preset(preset), .mem_reset_n(mem_reset_n)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: drives the bus while read is high, stores on write edges.
    logic [7:0] ram_mem [16];
    logic       corrupt9 = 1'b0;
    logic [7:0] ram_rd_val;
    assign ram_rd_val = ram_mem[address] ^ ((corrupt9 && address == 4'd9) ? 8'h3C : 8'h00);
    assign data = read ? ram_rd_val : 8'bz;

    always @(posedge clk) begin
        if (!mem_reset_n) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'h00;
        end else if (preset) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'hFF;
        end else if (write) begin
            ram_mem[address] <= data;
        end
    end

    // Reference model: what the client should see for each op.
    logic [7:0] ref_mem [16];

    task automatic model_txn(input logic [1:0] op, input logic [3:0] a, input logic [7:0] wd,
                             output logic [7:0] exp_rd, output logic exp_err, output int exp_lat);
        exp_err = 1'b0;
        exp_rd  = 8'h00;
        case (op)
            2'b00: begin exp_rd = ref_mem[a]; exp_lat = RD_LAT + 2; end
            2'b01: begin
                ref_mem[a] = wd;
`ifdef RAM16_WR_VERIFY_EN
                exp_rd  = wd ^ ((corrupt9 && a == 4'd9) ? 8'h3C : 8'h00);
                exp_err = (exp_rd != wd);
                exp_lat = RD_LAT + 4;
`else
                exp_lat = 2;
`endif
            end
            2'b10: begin for (int i = 0; i < 16; i++) ref_mem[i] = 8'hFF; exp_lat = PULSE_CYC + 1; end
            default: begin for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00; exp_lat = PULSE_CYC + 1; end
        endcase
    endtask

    // Drives one request and collects what the pins did; comparisons are made by the callers.
    task automatic run_txn(input logic [1:0] op, input logic [3:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output logic er, output int lat,
                           output int n_rd, output int n_wr, output int n_pre, output int n_clr,
                           output logic [7:0] wr_bus, output int viol, output bit tmo);
        int guard;
        rd = 8'h00; er = 1'b0; lat = 0; n_rd = 0; n_wr = 0; n_pre = 0; n_clr = 0;
        wr_bus = 8'h00; viol = 0; tmo = 1'b0; guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!req_ready) begin tmo = 1'b1; return; end
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            if (read) n_rd++;
            if (write) begin n_wr++; wr_bus = data; end
            if (preset) n_pre++;
            if (!mem_reset_n) n_clr++;
            if ((read && write) || (read && dut.w_bus_oe) || req_ready ||
                ((read || write) && address !== a)) viol++;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin tmo = 1'b1; return; end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid || dut.w_bus_oe) viol++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, read, write, preset, rsp_err, dut.w_bus_oe} !== 7'b0 ||
            address !== 4'd0 || rsp_rdata !== 8'd0 || mem_reset_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b rd=%b wr=%b pre=%b err=%b oe=%b addr=%h rdata=%h mrn=%b, required all 0 with mrn=1",
                     req_ready, rsp_valid, read, write, preset, rsp_err, dut.w_bus_oe, address, rsp_rdata, mem_reset_n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] rd, wb, er_rd; logic er, exp_er; int lat, nr, nw, np, nc, v, exp_lat; bit to;
        model_txn(2'b01, 4'd2, 8'h24, er_rd, exp_er, exp_lat);
        run_txn(2'b01, 4'd2, 8'h24, rd, er, lat, nr, nw, np, nc, wb, v, to);
        checks++;
        if (to || nw != 1 || wb !== 8'h24 || lat != exp_lat || v != 0) begin
            errors++;
            $display("FAIL write_pins: to=%0d wr_cycles=%0d bus=%h lat=%0d viol=%0d, required wr_cycles=1 bus=24 lat=%0d viol=0",
                     to, nw, wb, lat, v, exp_lat);
        end
        checks++;
        if (rd !== er_rd || er !== exp_er) begin
            errors++;
            $display("FAIL write_rsp: rdata=%h err=%b required rdata=%h err=%b", rd, er, er_rd, exp_er);
        end
        model_txn(2'b00, 4'd2, 8'h00, er_rd, exp_er, exp_lat);
        run_txn(2'b00, 4'd2, 8'h00, rd, er, lat, nr, nw, np, nc, wb, v, to);
        checks++;
        if (to || nr != RD_LAT || nw != 0 || lat != exp_lat || v != 0) begin
            errors++;
            $display("FAIL read_pins: to=%0d rd_cycles=%0d wr_cycles=%0d lat=%0d viol=%0d, required rd_cycles=%0d lat=%0d",
                     to, nr, nw, lat, v, RD_LAT, exp_lat);
        end
        checks++;
        if (rd !== 8'h24 || er !== 1'b0) begin
            errors++;
            $display("FAIL read_data: rdata=%h err=%b required 24 err=0", rd, er);
        end
    endtask

    task automatic test_preset_clear();
        logic [7:0] rd, wb, exp_rd; logic er, exp_er; int lat, nr, nw, np, nc, v, exp_lat; bit to;
        for (int k = 0; k < 2; k++) begin
            logic [1:0] op;
            op = (k == 0) ? 2'b10 : 2'b11;
            model_txn(op, 4'd4, 8'h00, exp_rd, exp_er, exp_lat);
            run_txn(op, 4'd4, 8'h00, rd, er, lat, nr, nw, np, nc, wb, v, to);
            checks++;
            if (to || np != ((k == 0) ? PULSE_CYC : 0) || nc != ((k == 1) ? PULSE_CYC : 0) ||
                lat != exp_lat || rd !== 8'h00 || v != 0) begin
                errors++;
                $display("FAIL ctl_pulse op=%b: to=%0d preset_cyc=%0d clear_cyc=%0d lat=%0d rdata=%h viol=%0d, required pulse %0d lat %0d rdata 00",
                         op, to, np, nc, lat, rd, v, PULSE_CYC, exp_lat);
            end
            model_txn(2'b00, 4'd4, 8'h00, exp_rd, exp_er, exp_lat);
            run_txn(2'b00, 4'd4, 8'h00, rd, er, lat, nr, nw, np, nc, wb, v, to);
            checks++;
            if (to || rd !== exp_rd || rd !== ((k == 0) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL ctl_readback op=%b: rdata=%h to=%0d required %h", op, rd, to, exp_rd);
            end
        end
    endtask

    task automatic test_rsp_stall();
        logic [7:0] exp_rd, held; logic exp_er; int exp_lat, guard; bit bad;
        model_txn(2'b00, 4'd2, 8'h00, exp_rd, exp_er, exp_lat);
        req_valid = 1'b1; req_op = 2'b00; req_addr = 4'd2;
        @(negedge clk);
        req_op = 2'b01; req_addr = 4'd3; req_wdata = 8'h77;
        guard = 0;
        while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
        held = rsp_rdata;
        bad = !rsp_valid;
        for (int c = 0; c < 5; c++) begin
            if (!rsp_valid || rsp_rdata !== held || req_ready || read || write) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad || held !== exp_rd) begin
            errors++;
            $display("FAIL rsp_stall: unstable_or_busy=%0d rdata=%h required stable rdata=%h", bad, held, exp_rd);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || write !== 1'b0) begin
            errors++;
            $display("FAIL rsp_release: rsp_valid=%b write=%b required 0 0", rsp_valid, write);
        end
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        req_valid = 1'b1; req_op = 2'b00; req_addr = 4'd5;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (read !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd_start: read=%b required 1", read);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (read !== 1'b0 || dut.w_bus_oe !== 1'b0 || rsp_valid !== 1'b0 || address !== 4'd0) begin
            errors++;
            $display("FAIL mid_rd_reset: read=%b oe=%b rsp_valid=%b addr=%h required 0 0 0 0",
                     read, dut.w_bus_oe, rsp_valid, address);
        end
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid || read) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_rd_no_rsp: response or read seen after reset, required none");
        end
    endtask

`ifdef RAM16_WR_VERIFY_EN
    task automatic test_verify_corrupt();
        logic [7:0] rd, wb, exp_rd; logic er, exp_er; int lat, nr, nw, np, nc, v, exp_lat; bit to;
        corrupt9 = 1'b1;
        model_txn(2'b01, 4'd9, 8'h5A, exp_rd, exp_er, exp_lat);
        run_txn(2'b01, 4'd9, 8'h5A, rd, er, lat, nr, nw, np, nc, wb, v, to);
        checks++;
        if (to || er !== 1'b1 || rd !== 8'h66 || rd !== exp_rd || lat != RD_LAT + 4) begin
            errors++;
            $display("FAIL verify_corrupt: rdata=%h err=%b lat=%0d to=%0d required rdata=66 err=1 lat=%0d",
                     rd, er, lat, to, RD_LAT + 4);
        end
        corrupt9 = 1'b0;
        ref_mem[9] = 8'h5A;
    endtask
`endif

    task automatic test_random();
        logic [7:0] rd, wb, exp_rd, wd; logic er, exp_er; logic [1:0] op; logic [3:0] a;
        int lat, nr, nw, np, nc, v, exp_lat, sel; bit to;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            op  = (sel == 0) ? 2'b10 : (sel == 1) ? 2'b11 : (sel < 6) ? 2'b01 : 2'b00;
            a   = 4'($urandom_range(0, 15));
            wd  = 8'($urandom_range(0, 255));
            model_txn(op, a, wd, exp_rd, exp_er, exp_lat);
            run_txn(op, a, wd, rd, er, lat, nr, nw, np, nc, wb, v, to);
            checks++;
            if (to || rd !== exp_rd || er !== exp_er || lat != exp_lat || v != 0 ||
                (op == 2'b01 && wb !== wd)) begin
                errors++;
                $display("FAIL random[%0d] op=%b addr=%h: rdata=%h err=%b lat=%0d viol=%0d to=%0d required rdata=%h err=%b lat=%0d",
                         n, op, a, rd, er, lat, v, to, exp_rd, exp_er, exp_lat);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin ram_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        test_reset();
        test_write_read();
        test_preset_clear();
        test_rsp_stall();
        test_reset_mid_read();
`ifdef RAM16_WR_VERIFY_EN
        test_verify_corrupt();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram16x8_bus_master.md
Name: ram16x8_bus_master

Overview:
- Initiator for the 16x8 bidirectional-data RAM. It turns client request/response handshakes into the RAM pin-level protocol: address, read, write, preset, reset, plus the shared tristate 8-bit data bus.
- It owns bus direction, bus turnaround and read-data capture.
- Sits between any client logic (DMA, CPU port, test sequencer) and the memory macro.

Parameters:
- RD_LAT, 1, cycles read is held high before data is sampled (1..4).
- PULSE_CYC, 1, length in cycles of preset/clear pulses to the RAM (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  master accepts a request this cycle.
- req_op  in  2  00 read, 01 write, 10 preset-all, 11 clear-all.
- req_addr  in  4  target address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  client accepts the response.
- rsp_rdata  out  8  read data, or readback data (see feature).
- rsp_err  out  1  write-verify mismatch.
- data  inout  8  shared RAM data bus.
- address  out  4  RAM address.
- read  out  1  RAM read strobe.
- write  out  1  RAM write strobe.
- preset  out  1  RAM preset pulse.
- mem_reset_n  out  1  RAM clear, active-low.

Behaviour:
- Reset (reset=0 at posedge):
  - All of these go low: state=IDLE, address=0, read, write, preset, req_ready, rsp_valid, rsp_rdata=0, rsp_err.
  - mem_reset_n=1; data bus released to Z.
  - Any transaction in flight is dropped and no response is issued.
- FSM states: IDLE, WR, RD, TURN, CTL, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready the master latches op/addr/wdata and drives req_ready=0 next cycle.
  - Next state: WR for write, RD for read, CTL for preset/clear.
- WR:
  - 1 cycle: address=addr, write=1, read=0, data driven with wdata.
  - Next cycle: write=0 and the bus is released. Then RSP (or TURN->RD with the feature).
- RD:
  - address=addr, read=1 for RD_LAT cycles; the bus is never driven.
  - data is sampled into rsp_rdata at the posedge ending the last RD cycle.
  - Then TURN.
- TURN:
  - 1 cycle with read=write=0 and no drive, so the RAM releases the bus before any master drive.
  - Then RSP.
- CTL:
  - preset=1 (op 10) or mem_reset_n=0 (op 11) for PULSE_CYC cycles, with address held.
  - Then RSP with rsp_rdata=0.
- RSP:
  - rsp_valid=1; rsp_rdata/rsp_err are held stable until rsp_ready.
  - rsp_valid&rsp_ready -> IDLE with rsp_valid=0.
  - A new request is not accepted in the same cycle (minimum 1 IDLE cycle between transactions).
- Invariants:
  - The data drive-enable is never 1 while read=1.
  - read and write are never high together.
  - Exactly one response per accepted request.
- Read latency, acceptance to rsp_valid: RD_LAT+2 cycles. Write latency: 2 cycles.
- req_valid with any req_op while not in IDLE: ignored, because req_ready=0.
- Address 15 and address 0 need no special handling; there is no wrap logic.
- X/Z sampled on the bus is passed through unchanged.

Optional Feature:
- Macro: RAM16_WR_VERIFY_EN.
- Defined:
  - Every write runs WR -> TURN -> RD -> TURN -> RSP.
  - rsp_rdata = readback value.
  - rsp_err=1 if readback != wdata, else 0.
  - Write latency becomes RD_LAT+4.
- Undefined:
  - The write path is WR -> RSP; rsp_rdata=0 for writes and rsp_err is tied 0.
  - No compare logic is synthesized.

Decomposition:
- Package ram16_master_pkg holds:
  - Op encodings: OP_RD, OP_WR, OP_PRESET, OP_CLEAR.
  - FSM state encodings.
  - ADDR_W=4, DATA_W=8.
- Sub-module ram16_bus_pad holds the tristate driver (drive enable + output register) and the input capture register, so all inout handling is isolated there.

Test Plan:
- Write addr 2 data 0x24 -> one-cycle pulse write=1, address=2, data=0x24; bus Z the next cycle; rsp_valid 2 cycles after accept, rsp_err=0.
- Read addr 2 after the above, with a RAM model returning 0x24 and RD_LAT=1 -> read high 1 cycle; rsp_rdata=0x24; the master never drives data while read=1; TURN cycle observed.
- Preset (op 10), PULSE_CYC=2, then read addr 4 -> preset high 2 cycles; the read returns 0xFF (model preset value).
- Clear (op 11), then read addr 4 -> mem_reset_n low PULSE_CYC cycles; the read returns 0x00.
- rsp_ready held 0 for 5 cycles while req_valid stays 1 -> rsp_valid/rsp_rdata stable, req_ready=0, no second transaction issued.
- reset pulled low mid-RD -> next edge read=0, bus Z, rsp_valid=0, no response. With RAM16_WR_VERIFY_EN and a model corrupting addr 9: write 0x5A -> rsp_err=1 and rsp_rdata equals the corrupted value.
